// File: rtl/writeback_arbiter.sv
// Three-requester register-file writeback arbiter with one-entry buffer per requester.
// Define WRITEBACK_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority 0 > 1 > 2.
module writeback_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic [2:0]           req_valid,
    output logic [2:0]           req_ready,
    input  logic [3*DEPTH-1:0]   req_index,
    input  logic [3*WIDTH-1:0]   req_data,
    output logic                 write_enable,
    output logic [DEPTH-1:0]     write_index,
    output logic [WIDTH-1:0]     write_data,
    output logic [2:0]           grant
);

    logic [2:0]             full_q, full_d;
    logic [2:0][DEPTH-1:0]  idx_q, idx_d;
    logic [2:0][WIDTH-1:0]  data_q, data_d;
    logic                   we_q, we_d;
    logic [DEPTH-1:0]       windex_q, windex_d;
    logic [WIDTH-1:0]       wdata_q, wdata_d;
    logic [2:0]             grant_q, grant_d;
    logic [2:0]             sel;
    logic [2:0]             accept;

`ifdef WRITEBACK_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand0, cand1, cand2;

    function automatic logic [1:0] next_req(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Later assignments override earlier ones, so cand0 (pointer+1) wins.
    always_comb begin
        cand0 = next_req(ptr_q);
        cand1 = next_req(cand0);
        cand2 = next_req(cand1);
        sel   = '0;
        if (!hold) begin
            if (full_q[cand2]) sel = 3'b001 << cand2;
            if (full_q[cand1]) sel = 3'b001 << cand1;
            if (full_q[cand0]) sel = 3'b001 << cand0;
        end
        ptr_d = ptr_q;
        if (sel[0]) ptr_d = 2'd0;
        if (sel[1]) ptr_d = 2'd1;
        if (sel[2]) ptr_d = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= 2'd2;
        else       ptr_q <= ptr_d;
    end
`else
    always_comb begin
        sel = '0;
        if (!hold) begin
            if (full_q[0])      sel = 3'b001;
            else if (full_q[1]) sel = 3'b010;
            else if (full_q[2]) sel = 3'b100;
        end
    end
`endif

    // Ready depends only on state and hold; a selected buffer can refill as it drains.
    assign req_ready = reset ? 3'b000 : (~full_q | sel);
    assign accept    = req_valid & req_ready;

    always_comb begin
        full_d   = full_q & ~sel;
        idx_d    = idx_q;
        data_d   = data_q;
        we_d     = |sel;
        grant_d  = sel;
        windex_d = windex_q;
        wdata_d  = wdata_q;
        for (int i = 0; i < 3; i++) begin
            // Writes to index 0 are acknowledged and discarded.
            if (accept[i] && (req_index[i*DEPTH +: DEPTH] != '0)) begin
                full_d[i] = 1'b1;
                idx_d[i]  = req_index[i*DEPTH +: DEPTH];
                data_d[i] = req_data[i*WIDTH +: WIDTH];
            end
            if (sel[i]) begin
                windex_d = idx_q[i];
                wdata_d  = data_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        idx_q  <= idx_d;
        data_q <= data_d;
        if (reset) begin
            full_q   <= '0;
            we_q     <= 1'b0;
            grant_q  <= '0;
            windex_q <= '0;
            wdata_q  <= '0;
        end else begin
            full_q   <= full_d;
            we_q     <= we_d;
            grant_q  <= grant_d;
            windex_q <= windex_d;
            wdata_q  <= wdata_d;
        end
    end

    assign write_enable = we_q;
    assign write_index  = windex_q;
    assign write_data   = wdata_q;
    assign grant        = grant_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter; follows WRITEBACK_ROUND_ROBIN_EN if defined.
module tb_writeback_arbiter;
    localparam int WIDTH = 32;
    localparam int DEPTH = 5;

    logic               clk;
    logic               reset;
    logic               hold;
    logic [2:0]         req_valid;
    logic [2:0]         req_ready;
    logic [3*DEPTH-1:0] req_index;
    logic [3*WIDTH-1:0] req_data;
    logic               write_enable;
    logic [DEPTH-1:0]   write_index;
    logic [WIDTH-1:0]   write_data;
    logic [2:0]         grant;

    typedef struct {
        logic [DEPTH-1:0] idx;
        logic [WIDTH-1:0] data;
        logic [2:0]       gnt;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    writeback_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_data(req_data),
        .write_enable(write_enable), .write_index(write_index),
        .write_data(write_data), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every observed write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write idx=%0d data=%h grant=%b cyc=%0d",
                         write_index, write_data, grant, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (write_index !== mon_e.idx || write_data !== mon_e.data ||
                    grant !== mon_e.gnt || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
                    errors++;
                    $display("FAIL write got idx=%0d data=%h grant=%b cyc=%0d want idx=%0d data=%h grant=%b cyc=%0d",
                             write_index, write_data, grant, cyc,
                             mon_e.idx, mon_e.data, mon_e.gnt, mon_e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DEPTH-1:0] idx, input logic [WIDTH-1:0] data,
                        input logic [2:0] gnt, input int c);
        exp_t e;
        e.idx = idx; e.data = data; e.gnt = gnt; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1; hold = 1'b0; req_valid = '0; req_index = '0; req_data = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        @(negedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (write_enable !== 1'b0 || grant !== 3'b000) begin
                errors++;
                $display("FAIL %s_idle we=%b grant=%b want 0/000", name, write_enable, grant);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; hold = 1'b0; req_valid = 3'b111;
        req_index = {5'd3, 5'd2, 5'd1}; req_data = {32'hC, 32'hB, 32'hA};
        tick(); tick();
        @(negedge clk);
        checks++;
        if (write_enable !== 1'b0 || grant !== 3'b000 || write_index !== '0 ||
            write_data !== '0 || req_ready !== 3'b000) begin
            errors++;
            $display("FAIL reset_state we=%b grant=%b idx=%0d data=%h ready=%b want 0/000/0/0/000",
                     write_enable, grant, write_index, write_data, req_ready);
        end
        tick();
        reset = 1'b0; req_valid = '0;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready got=%b want 111", req_ready);
        end
        check_idle("reset_drop", 3);
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 3'b001; req_index[0 +: DEPTH] = 5'd5; req_data[0 +: WIDTH] = 32'hDEADBEEF;
        push(5'd5, 32'hDEADBEEF, 3'b001, cyc + 2);
        tick();
        req_valid = '0;
        tick();
        check_idle("single_after", 1);
        wait_drain("single");
    endtask

    task automatic test_x0_drop();
        do_reset();
        req_valid = 3'b010; req_index[DEPTH +: DEPTH] = 5'd0; req_data[WIDTH +: WIDTH] = 32'h1234;
        @(negedge clk);
        checks++;
        if (req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready got=%b want 1", req_ready[1]);
        end
        tick();
        req_valid = '0;
        check_idle("x0", 4);
    endtask

    task automatic test_contention();
        int c;
        logic [2:0] g;
        do_reset();
        req_valid = 3'b111;
        req_index = {5'd3, 5'd2, 5'd1};
        req_data  = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
        c = cyc;
        for (int k = 0; k < 8; k++) begin
`ifdef WRITEBACK_ROUND_ROBIN_EN
            g = 3'b001 << (k % 3);
`else
            g = (k < 6) ? 3'b001 : (3'b001 << (k - 5));
`endif
            if (g == 3'b001)      push(5'd1, 32'hAAAA0001, g, c + 2 + k);
            else if (g == 3'b010) push(5'd2, 32'hBBBB0002, g, c + 2 + k);
            else                  push(5'd3, 32'hCCCC0003, g, c + 2 + k);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k < 5) begin
`ifdef WRITEBACK_ROUND_ROBIN_EN
                g = 3'b001 << (k % 3);
`else
                g = 3'b001;
`endif
                @(negedge clk);
                checks++;
                if (req_ready !== g) begin
                    errors++;
                    $display("FAIL contention_ready k=%0d got=%b want %b", k, req_ready, g);
                end
            end
        end
        req_valid = '0;
        wait_drain("contention");
    endtask

    task automatic test_hold();
        do_reset();
        hold = 1'b1; req_valid = 3'b101;
        req_index = {5'd6, 5'd0, 5'd4};
        req_data  = {32'h66, 32'h0, 32'h44};
        tick();
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            checks++;
            if (write_enable !== 1'b0 || grant !== 3'b000 || req_ready !== 3'b010) begin
                errors++;
                $display("FAIL hold_state i=%0d we=%b grant=%b ready=%b want 0/000/010",
                         i, write_enable, grant, req_ready);
            end
        end
        tick();
        hold = 1'b0;
        push(5'd4, 32'h44, 3'b001, cyc + 1);
        push(5'd6, 32'h66, 3'b100, cyc + 2);
        wait_drain("hold");
    endtask

    task automatic test_reset_mid();
        do_reset();
        hold = 1'b1; req_valid = 3'b011;
        req_index = {5'd0, 5'd9, 5'd7};
        req_data  = {32'h0, 32'h99, 32'h77};
        tick();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b100) begin
            errors++;
            $display("FAIL resetmid_full ready=%b want 100", req_ready);
        end
        tick();
        reset = 1'b1; hold = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL resetmid_inreset ready=%b want 000", req_ready);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (write_enable !== 1'b0 || grant !== 3'b000 || req_ready !== 3'b111) begin
            errors++;
            $display("FAIL resetmid_after we=%b grant=%b ready=%b want 0/000/111",
                     write_enable, grant, req_ready);
        end
        check_idle("resetmid", 4);
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; req_valid = '0; req_index = '0; req_data = '0;
        test_reset();
        test_single();
        test_x0_drop();
        test_contention();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
